intersection_controller: RTL

Sequences a two-approach intersection: main road A and side road B, each with its own red/amber/green lamp set. A rests on green. B is served only after a latched vehicle-detector request, with an all-red clearance interval between conflicting greens. The block sits above the per-lamp timing level and owns all phase timing for both approaches.

---
 rtl/intersection_controller.sv | 113 +++++++++++
 1 files changed

// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer: A rests on green, B served on latched demand
// with all-red clearance. Define PED_WALK_EN to add the pedestrian WALK phase.
module intersection_controller #(
  parameter int T_GO_A  = 20,
  parameter int T_GO_B  = 15,
  parameter int T_WARN  = 3,
  parameter int T_CLEAR = 2,
`ifdef PED_WALK_EN
  parameter int T_WALK  = 10,
`endif
  parameter int CW      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_b,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic       a_r,
  output logic       a_a,
  output logic       a_v,
  output logic       b_r,
  output logic       b_a,
  output logic       b_v,
  output logic [2:0] phase
);

  localparam logic [2:0] RED_BA = 3'd0;
  localparam logic [2:0] A_GO   = 3'd1;
  localparam logic [2:0] A_WARN = 3'd2;
  localparam logic [2:0] RED_AB = 3'd3;
  localparam logic [2:0] B_GO   = 3'd4;
  localparam logic [2:0] B_WARN = 3'd5;
  localparam logic [2:0] WALK   = 3'd6;

  localparam logic [CW-1:0] TGA  = CW'(T_GO_A);
  localparam logic [CW-1:0] TGB  = CW'(T_GO_B);
  localparam logic [CW-1:0] TWN  = CW'(T_WARN);
  localparam logic [CW-1:0] TCL  = CW'(T_CLEAR);
  localparam logic [CW-1:0] ONE  = CW'(1);
`ifdef PED_WALK_EN
  localparam logic [CW-1:0] TWK  = CW'(T_WALK);
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_b_q, pend_b_d;
  logic          pend_p_q, pend_p_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RED_BA;
      cnt_q    <= ONE;
      pend_b_q <= 1'b0;
      pend_p_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_b_q <= pend_b_d;
      pend_p_q <= pend_p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RED_BA: if (cnt_q == TCL) state_d = A_GO;
      A_GO:   if (cnt_q >= TGA && (pend_b_q || pend_p_q)) state_d = A_WARN;
      A_WARN: if (cnt_q == TWN) state_d = RED_AB;
      RED_AB: if (cnt_q == TCL) state_d = pend_p_q ? WALK : B_GO;
      B_GO:   if (cnt_q == TGB) state_d = B_WARN;
      B_WARN: if (cnt_q == TWN) state_d = RED_BA;
`ifdef PED_WALK_EN
      WALK:   if (cnt_q == TWK) state_d = pend_b_q ? B_GO : RED_BA;
`endif
      default: state_d = RED_BA;
    endcase

    // Every entry restarts the count; A_GO parks at its minimum instead of wrapping.
    if (state_d != state_q)                    cnt_d = ONE;
    else if (state_q == A_GO && cnt_q >= TGA)  cnt_d = cnt_q;
    else                                       cnt_d = cnt_q + ONE;

    pend_b_d = pend_b_q | (req_b && state_q != B_GO);
    if (state_d == B_GO && state_q != B_GO) pend_b_d = 1'b0;

`ifdef PED_WALK_EN
    pend_p_d = pend_p_q | (ped_req && state_q != WALK);
    if (state_d == WALK && state_q != WALK) pend_p_d = 1'b0;
`else
    pend_p_d = 1'b0;
`endif
  end

  // Lamps default to all-red, which also covers any unreachable state code.
  always_comb begin
    a_r = 1'b1; a_a = 1'b0; a_v = 1'b0;
    b_r = 1'b1; b_a = 1'b0; b_v = 1'b0;
    case (state_q)
      A_GO:   begin a_r = 1'b0; a_v = 1'b1; end
      A_WARN: begin a_r = 1'b0; a_a = 1'b1; end
      B_GO:   begin b_r = 1'b0; b_v = 1'b1; end
      B_WARN: begin b_r = 1'b0; b_a = 1'b1; end
      default: ;
    endcase
    phase = state_q;
`ifdef PED_WALK_EN
    walk = (state_q == WALK);
`endif
  end

endmodule
